booth_mult16: RTL and testbench

- Iterative radix-2 Booth multiplier for 16-bit two's-complement operands, producing a 32-bit signed product.
- Sits directly downstream of the LU 16-bit two's-complement negation stage: the negated multiplicand (~a + 1) is formed once per operation and then added on Booth "10" steps.
- One Booth step per clock. A start/busy/done handshake lets the control sequencer issue back-to-back multiplies.

---
 rtl/booth_mult16.sv | 120 ++++++++++++
 tb/tb_booth_mult16.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult16.sv
// booth_mult16: iterative radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH product.
// Latency: done is visible WIDTH clocks after the accepted start edge. Throughput is one result per WIDTH+1 clocks.
// Backpressure: start is ignored while busy. It is accepted in IDLE, and in DONE for back-to-back issue.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - request; sampled when not busy, latches a/b
//   a, b        - signed multiplicand / multiplier
//   busy        - high while the Booth steps are iterating
//   done        - one-cycle pulse when product is updated
//   product     - signed result, held until the next completion

module booth_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // The accumulator and multiplicand are one bit wider than the operands.
    // This lets -2^(WIDTH-1) be negated without overflow.
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic               r_q_m1;
    logic [WIDTH:0]     r_mcand;
    logic [WIDTH:0]     r_neg_mcand;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_last;
    logic [WIDTH:0]     w_mcand_ext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;

    assign w_load      = start && (r_state != S_RUN);
    assign w_last      = (r_state == S_RUN) && (r_count == CW'(1));
    assign w_mcand_ext = {a[WIDTH-1], a};

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_count == CW'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Booth recode on {mq[0], q_m1}: 01 adds the multiplicand, 10 subtracts it.
    // The 17-bit add wraps, so the carry-out is dropped.
    always_comb begin
        w_sum = r_acc;
        case ({r_mq[0], r_q_m1})
            2'b01:   w_sum = r_acc + r_mcand;
            2'b10:   w_sum = r_acc + r_neg_mcand;
            default: w_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of {acc, mq, q_m1}. The sign bit of the sum is replicated.
    assign w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_mq        <= '0;
            r_q_m1      <= 1'b0;
            r_mcand     <= '0;
            r_neg_mcand <= '0;
            r_count     <= '0;
            r_product   <= '0;
        end else if (w_load) begin
            r_acc       <= '0;
            r_mq        <= b;
            r_q_m1      <= 1'b0;
            r_mcand     <= w_mcand_ext;
            r_neg_mcand <= ~w_mcand_ext + 1'b1;
            r_count     <= CW'(WIDTH);
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_nxt;
            r_mq    <= w_mq_nxt;
            r_q_m1  <= r_mq[0];
            r_count <= r_count - 1'b1;
            // The product is taken from the post-shift value of the final step.
            if (w_last) r_product <= {w_acc_nxt[WIDTH-1:0], w_mq_nxt};
        end
    end

    // Status outputs decode the state directly. Reset therefore clears them without a clock edge.
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_booth_mult16.sv
module tb_booth_mult16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    booth_mult16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and wait for done. Latency is counted in edges after the start edge.
    task automatic mul(input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic [31:0] exp, input string tag,
                       output int lat, output int busy_cnt);
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        lat = -1;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd16);
        chk(tag, product, exp);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    endtask

    int lat, bcnt, dcnt, t1, t2;
    logic [31:0] p1, p2;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_done",    {31'd0, done}, 32'd0);
        chk("rst_product", product,       32'd0);
        @(negedge clk); rst_n = 1'b1;

        mul(16'd3, 16'd5, 32'h0000000F, "3x5", lat, bcnt);
        chk("3x5_busy_cycles", 32'(bcnt), 32'd16);
        chk("3x5_idle", {31'd0, busy}, 32'd0);

        mul(16'hFFF9, 16'd6,    32'hFFFFFFD6, "m7x6",   lat, bcnt);
        mul(16'h8000, 16'h8000, 32'h40000000, "minxmin", lat, bcnt);
        mul(16'h8000, 16'h7FFF, 32'hC0008000, "minxmax", lat, bcnt);
        mul(16'h0000, 16'h8000, 32'h00000000, "0xmin",  lat, bcnt);

        // A start pulse during RUN is ignored.
        @(negedge clk);
        a = 16'd100; b = 16'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a = 16'd1; b = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; p1 = '0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                dcnt++;
                p1 = product;
            end
            @(posedge clk); #1;
        end
        chk("ign_done_count", 32'(dcnt), 32'd1);
        chk("ign_product", p1, 32'h00004E20);
        chk("ign_no_relaunch", {31'd0, busy}, 32'd0);

        // Back-to-back issue with start held high.
        @(negedge clk);
        a = 16'd2; b = 16'hFFFD; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFC; b = 16'hFFFB;
        t1 = -1; t2 = -1; p1 = '0; p2 = '0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 17) start = 1'b0;
            if (done) begin
                if (t1 < 0) begin
                    t1 = k;
                    p1 = product;
                end else begin
                    t2 = k;
                    p2 = product;
                    break;
                end
            end
        end
        chk("b2b_first_lat", 32'(t1), 32'd16);
        chk("b2b_gap", 32'(t2 - t1), 32'd17);
        chk("b2b_p1", p1, 32'hFFFFFFFA);
        chk("b2b_p2", p2, 32'h00000014);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a = 16'd123; b = 16'd45; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",    {31'd0, busy}, 32'd0);
        chk("mid_rst_done",    {31'd0, done}, 32'd0);
        chk("mid_rst_product", product,       32'd0);
        @(negedge clk); rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("mid_no_done", 32'(dcnt), 32'd0);
        mul(16'd9, 16'd9, 32'h00000051, "9x9", lat, bcnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
